// File: rtl/fp_out_pkg.sv
// Shared types and helpers for the FP multiplier output buffer.
package fp_out_pkg;

  localparam int FLAG_W        = 3;
  localparam int FLAG_NAN_BIT  = 2;
  localparam int FLAG_INF_BIT  = 1;
  localparam int FLAG_ZERO_BIT = 0;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_flags_t;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fp_out_fifo_mem.sv
// Register-array storage for the output FIFO: one write port, one asynchronous read port.
module fp_out_fifo_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fp_out_buffer.sv
// FIFO output stage for the FP multiplier with ready/accept handshake and core back-pressure.
// Optional per-entry exception flags when FP_OUT_BUFFER_EXC_FLAGS_EN is defined.
module fp_out_buffer
  import fp_out_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int EXP_W       = 8,
  parameter int DEPTH       = 4,
  parameter int ACCEPT_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         doneFP,
  input  logic [WIDTH-1:0]             FPoutBus,
  output logic                         fpStall,
  input  logic                         resultAccept,
  output logic [WIDTH-1:0]             outBus,
  output logic                         resultReady,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
`ifdef FP_OUT_BUFFER_EXC_FLAGS_EN
  ,
  output logic [FLAG_W-1:0]            outFlags
`endif
);

  localparam int CNT_W = count_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int MAN_W = WIDTH - 1 - EXP_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fp_out_buffer: DEPTH must be a power of two and at least 2");
  end
  if (EXP_W < 1 || MAN_W < 1) begin : g_bad_exp_w
    $error("fp_out_buffer: EXP_W leaves no room for a mantissa");
  end
  if (ACCEPT_MODE != 0 && ACCEPT_MODE != 1) begin : g_bad_mode
    $error("fp_out_buffer: ACCEPT_MODE must be 0 or 1");
  end

`ifdef FP_OUT_BUFFER_EXC_FLAGS_EN
  localparam int STORE_W = WIDTH + FLAG_W;
`else
  localparam int STORE_W = WIDTH;
`endif

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               accept_prev_q, accept_prev_d;
  logic               empty, full, pop_req, push, pop;
  logic [STORE_W-1:0] wr_data, rd_data;

  always_comb begin
    empty         = (count_q == '0);
    full          = (count_q == FULL_CNT);
    // Edge mode: a rising edge is consumed even when nothing is there to pop.
    pop_req       = (ACCEPT_MODE == 1) ? (resultAccept && !accept_prev_q) : resultAccept;
    push          = doneFP && !full;
    pop           = !empty && pop_req;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    accept_prev_d = resultAccept;
    overflow_d    = overflow_q | (doneFP & full);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      accept_prev_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      accept_prev_q <= accept_prev_d;
    end
  end

`ifdef FP_OUT_BUFFER_EXC_FLAGS_EN
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  logic             exp_ones;
  fp_flags_t        in_flags;

  always_comb begin
    in_exp           = FPoutBus[WIDTH-2 -: EXP_W];
    in_man           = FPoutBus[MAN_W-1:0];
    exp_ones         = &in_exp;
    in_flags.is_zero = (in_exp == '0) && (in_man == '0);
    in_flags.is_inf  = exp_ones && (in_man == '0);
    in_flags.is_nan  = exp_ones && (in_man != '0);
    wr_data          = {in_flags, FPoutBus};
  end

  assign outFlags = resultReady ? rd_data[WIDTH +: FLAG_W] : '0;
`else
  assign wr_data = FPoutBus;
`endif

  fp_out_fifo_mem #(
    .W     (STORE_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !rst),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign resultReady = !empty;
  assign fpStall     = full;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign outBus      = resultReady ? rd_data[WIDTH-1:0] : '0;

endmodule
